// File: rtl/sw_arm_sync_ctrl_if.sv
// Control/status bundle between the software register bridge and sync control.
// Carries the control word, external sync level, regenerated sync and readback status.
interface sw_arm_sync_ctrl_if;
  logic [31:0] ctrl_reg;
  logic        ext_sync;
  logic        sync_out;
  logic        armed;
  logic [31:0] status;

  modport master (
    output ctrl_reg,
    output ext_sync,
    input  sync_out,
    input  armed,
    input  status
  );

  modport slave (
    input  ctrl_reg,
    input  ext_sync,
    output sync_out,
    output armed,
    output status
  );
endinterface

// File: rtl/sw_arm_sync_ctrl.sv
// Software arm/force/clear decode and periodic sync regeneration.
// Control edges act two cycles after ctrl_reg changes; status lags state by one.
module sw_arm_sync_ctrl #(
  parameter int unsigned SYNC_PERIOD = 1048576,
  parameter int unsigned PULSE_LEN   = 1
) (
  input  logic              user_clk,
  input  logic              user_rst,
  sw_arm_sync_ctrl_if.slave bus
);

  localparam int unsigned PW =
    (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam int unsigned LW =
    (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PW-1:0] PER_RELOAD =
    PW'(SYNC_PERIOD - 1);
  localparam logic [LW-1:0] LEN_RELOAD =
    LW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;

  logic [3:0]    ctrl_q;
  logic [3:0]    ctrl_qq;
  logic          ext_q;
  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] per_q;
  logic [PW-1:0] per_d;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_d;
  logic          sync_q;
  logic          sync_d;
  logic [7:0]    arm_cnt_q;
  logic [7:0]    arm_cnt_d;
  logic [15:0]   ext_cnt_q;
  logic [15:0]   ext_cnt_d;
  logic          armed_q;
  logic [31:0]   status_q;

  logic [3:0] ctrl_rise;
  logic       dis;
  logic       arm_e;
  logic       frc_e;
  logic       clr_e;
  logic       ext_e;
  logic       start;
  logic       kill;
  logic       arm_inc;
  logic       ctrl_unused;

  assign ctrl_unused = ^bus.ctrl_reg[31:4];

  // Disable is a level; while it is up every other command edge is swallowed.
  always_comb begin
    ctrl_rise = ctrl_q & ~ctrl_qq;
    dis       = ctrl_q[3];
    arm_e     = ctrl_rise[0] & ~dis;
    frc_e     = ctrl_rise[1] & ~dis;
    clr_e     = ctrl_rise[2] & ~dis;
    ext_e     = bus.ext_sync & ~ext_q;
  end

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    start   = 1'b0;
    kill    = 1'b0;
    arm_inc = 1'b0;
    if (dis) begin
      state_d = IDLE;
      kill    = 1'b1;
    end else if (frc_e) begin
      start   = 1'b1;
      state_d = RUN;
    end else if (arm_e && state_q != ARMED) begin
      state_d = ARMED;
      arm_inc = 1'b1;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (ext_e) begin
            start   = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (per_q == '0) begin
            start = 1'b1;
          end else begin
            per_d = per_q - PW'(1);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    if (start) begin
      per_d = PER_RELOAD;
    end
  end

  // A restart during an active pulse just reloads the width count.
  always_comb begin
    sync_d = sync_q;
    len_d  = len_q;
    if (kill) begin
      sync_d = 1'b0;
      len_d  = '0;
    end else if (start) begin
      sync_d = 1'b1;
      len_d  = LEN_RELOAD;
    end else if (len_q != '0) begin
      len_d = len_q - LW'(1);
    end else begin
      sync_d = 1'b0;
    end
  end

  always_comb begin
    arm_cnt_d = arm_cnt_q + {7'd0, arm_inc};
    ext_cnt_d = ext_cnt_q + {15'd0, ext_e};
    if (clr_e) begin
      arm_cnt_d = '0;
      ext_cnt_d = '0;
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      ctrl_q    <= '0;
      ctrl_qq   <= '0;
      ext_q     <= 1'b0;
      state_q   <= IDLE;
      per_q     <= '0;
      len_q     <= '0;
      sync_q    <= 1'b0;
      arm_cnt_q <= '0;
      ext_cnt_q <= '0;
      armed_q   <= 1'b0;
      status_q  <= '0;
    end else begin
      ctrl_q    <= bus.ctrl_reg[3:0];
      ctrl_qq   <= ctrl_q;
      ext_q     <= bus.ext_sync;
      state_q   <= state_d;
      per_q     <= per_d;
      len_q     <= len_d;
      sync_q    <= sync_d;
      arm_cnt_q <= arm_cnt_d;
      ext_cnt_q <= ext_cnt_d;
      armed_q   <= (state_q == ARMED);
      status_q  <= {arm_cnt_q, ext_cnt_q,
                    6'b0, state_q};
    end
  end

  assign bus.sync_out = sync_q;
  assign bus.armed    = armed_q;
  assign bus.status   = status_q;

endmodule

// File: tb/tb_sw_arm_sync_ctrl.sv
// Bench for sw_arm_sync_ctrl: vector table, corner sequences and random stimulus
// against a timestamp-based reference model.
module tb_sw_arm_sync_ctrl;

  localparam int P  = 16;
  localparam int PL = 2;

  logic clk;
  logic rst;

  sw_arm_sync_ctrl_if bus();
  sw_arm_sync_ctrl_if bus4();

  assign bus4.ctrl_reg = bus.ctrl_reg;
  assign bus4.ext_sync = bus.ext_sync;

  sw_arm_sync_ctrl #(.SYNC_PERIOD(P), .PULSE_LEN(PL)) dut (
    .user_clk(clk),
    .user_rst(rst),
    .bus(bus)
  );

  sw_arm_sync_ctrl #(.SYNC_PERIOD(P), .PULSE_LEN(4)) dut4 (
    .user_clk(clk),
    .user_rst(rst),
    .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference model: commands from sampled history, pulses/periods as timestamps.
  longint      n;
  longint      m_hi;
  longint      m_fire;
  int          m_st;
  int          m_armc;
  int          m_extc;
  logic [31:0] m_c1;
  logic [31:0] m_c2;
  logic        m_eprev;
  logic        m_sync;
  logic        m_armed;
  logic [31:0] m_status;

  task automatic model_reset();
    n = 0; m_hi = 0; m_fire = 0;
    m_st = 0; m_armc = 0; m_extc = 0;
    m_c1 = 0; m_c2 = 0; m_eprev = 0;
  endtask

  task automatic model_step(input logic [31:0] c, input logic e);
    logic [3:0] rise;
    logic dis, ee, st;
    n++;
    rise = m_c1[3:0] & ~m_c2[3:0];
    dis = m_c1[3];
    ee = e & ~m_eprev;
    m_armed = (m_st == 1);
    m_status = {8'(m_armc), 16'(m_extc), 6'd0, 2'(m_st)};
    st = 1'b0;
    if (dis) begin
      m_st = 0; m_hi = n;
    end else if (rise[1]) begin
      st = 1'b1; m_st = 2;
    end else if (rise[0] && m_st != 1) begin
      m_st = 1; m_armc = (m_armc + 1) % 256;
    end else if (m_st == 1 && ee) begin
      st = 1'b1; m_st = 2;
    end else if (m_st == 2 && n == m_fire) begin
      st = 1'b1;
    end
    if (st) begin
      m_hi = n + PL; m_fire = n + P;
    end
    if (ee) m_extc = (m_extc + 1) % 65536;
    if (rise[2] && !dis) begin
      m_armc = 0; m_extc = 0;
    end
    m_sync = (n < m_hi);
    m_c2 = m_c1; m_c1 = c; m_eprev = e;
  endtask

  // Entered and left at a negedge.
  task automatic tick(input logic [31:0] c, input logic e);
    bus.ctrl_reg = c;
    bus.ext_sync = e;
    @(posedge clk);
    model_step(c, e);
    #1;
    chk("sync_out", {31'd0, bus.sync_out}, {31'd0, m_sync});
    chk("armed", {31'd0, bus.armed}, {31'd0, m_armed});
    chk("status", bus.status, m_status);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ctrl_reg = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      bus.ext_sync = ~bus.ext_sync;
      @(posedge clk);
      #1;
      chk("rst_sync", {31'd0, bus.sync_out}, 32'd0);
      chk("rst_status", bus.status, 32'd0);
      @(negedge clk);
    end
    bus.ext_sync = 1'b0;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ctrl;
    logic        ext;
    logic        sync;
    logic        armed;
    logic [31:0] status;
  } vec_t;

  vec_t tbl[16];
  logic [31:0] r;
  logic        re;

  initial begin
    tbl[0]  = '{32'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{32'd2, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{32'd2, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{32'd2, 1'b0, 1'b1, 1'b0, 32'h2};
    tbl[4]  = '{32'd0, 1'b0, 1'b0, 1'b0, 32'h2};
    tbl[5]  = '{32'd3, 1'b0, 1'b0, 1'b0, 32'h2};
    tbl[6]  = '{32'd3, 1'b0, 1'b1, 1'b0, 32'h2};
    tbl[7]  = '{32'd3, 1'b0, 1'b1, 1'b0, 32'h2};
    tbl[8]  = '{32'd3, 1'b0, 1'b0, 1'b0, 32'h2};
    tbl[9]  = '{32'd0, 1'b0, 1'b0, 1'b0, 32'h2};
    tbl[10] = '{32'd1, 1'b0, 1'b0, 1'b0, 32'h2};
    tbl[11] = '{32'd1, 1'b0, 1'b0, 1'b0, 32'h2};
    tbl[12] = '{32'd1, 1'b0, 1'b0, 1'b1, 32'h01000001};
    tbl[13] = '{32'd1, 1'b1, 1'b1, 1'b1, 32'h01000001};
    tbl[14] = '{32'd1, 1'b1, 1'b1, 1'b0, 32'h01000102};
    tbl[15] = '{32'd1, 1'b0, 1'b0, 1'b0, 32'h01000102};

    rst = 1'b1;
    bus.ctrl_reg = 0;
    bus.ext_sync = 1'b0;
    @(negedge clk);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].ctrl, tbl[i].ext);
      chk($sformatf("tbl%0d_sync", i),
          {31'd0, bus.sync_out}, {31'd0, tbl[i].sync});
      chk($sformatf("tbl%0d_armed", i),
          {31'd0, bus.armed}, {31'd0, tbl[i].armed});
      chk($sformatf("tbl%0d_status", i),
          bus.status, tbl[i].status);
    end

    // Arm, then ext sync: pulses every P cycles, ext edges in RUN ignored.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 1'b0);
    chk("armed_wait", {31'd0, bus.armed}, 32'd1);
    tick(1, 1'b1);
    chk("ext_start", {31'd0, bus.sync_out}, 32'd1);
    for (int k = 1; k < 40; k++) begin
      tick(1, (k < 3) || (k >= 9 && k < 12));
      chk($sformatf("period_k%0d", k),
          {31'd0, bus.sync_out}, {31'd0, (k % P) < PL});
    end
    chk("arm_cnt_one", {24'd0, bus.status[31:24]}, 32'd1);

    // Ext counting, then clear coinciding with an ext edge.
    do_reset();
    tick(0, 1); tick(0, 0); tick(0, 1);
    tick(0, 0); tick(0, 1); tick(0, 0);
    tick(4, 0);
    chk("ext_cnt3", {16'd0, bus.status[23:8]}, 32'd3);
    tick(4, 1);
    tick(4, 0);
    chk("clr_wins", {16'd0, bus.status[23:8]}, 32'd0);

    // 258 arm edges alternating with force: arm_cnt wraps to 2.
    do_reset();
    for (int i = 0; i < 516; i++) tick((i % 2) ? 2 : 1, 1'b0);
    tick(0, 1'b0);
    tick(0, 1'b0);
    chk("arm_wrap", {24'd0, bus.status[31:24]}, 32'd2);

    // Disable truncates a pulse and masks arm edges.
    do_reset();
    tick(2, 0);
    tick(10, 0);
    chk("dis_pre", {31'd0, bus.sync_out}, 32'd1);
    tick(10, 0);
    chk("dis_trunc", {31'd0, bus.sync_out}, 32'd0);
    tick(9, 0);
    chk("dis_idle", {30'd0, bus.status[1:0]}, 32'd0);
    tick(9, 0); tick(8, 0); tick(9, 0); tick(9, 0);
    tick(1, 0); tick(1, 0); tick(1, 0); tick(1, 0);
    chk("dis_noarm", {31'd0, bus.armed}, 32'd0);
    chk("dis_armcnt", {24'd0, bus.status[31:24]}, 32'd0);
    chk("dis_state", {30'd0, bus.status[1:0]}, 32'd0);

    // Random traffic against the model.
    do_reset();
    r = 0;
    re = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) r[0] = ~r[0];
      if ($urandom_range(24) == 0) r[1] = ~r[1];
      if ($urandom_range(14) == 0) r[2] = ~r[2];
      if (r[3]) r[3] = ($urandom_range(3) != 0);
      else r[3] = ($urandom_range(59) == 0);
      r[31:4] = 28'($urandom);
      if ($urandom_range(2) == 0) re = ~re;
      tick(r, re);
    end

    // Async reset in the middle of a 4-cycle pulse.
    do_reset();
    tick(2, 0);
    tick(2, 0);
    tick(2, 0);
    chk("w4_mid", {31'd0, bus4.sync_out}, 32'd1);
    rst = 1'b1;
    #1;
    chk("w4_async_sync", {31'd0, bus4.sync_out}, 32'd0);
    chk("w4_async_status", bus4.status, 32'd0);
    model_reset();
    bus.ctrl_reg = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.ext_sync = ~bus.ext_sync;
      @(posedge clk);
      #1;
      chk("w4_hold", {31'd0, bus4.sync_out}, 32'd0);
    end
    @(negedge clk);
    bus.ext_sync = 1'b0;
    rst = 1'b0;
    tick(1, 0);
    tick(1, 0);
    chk("w4_armed_lag", {31'd0, bus4.armed}, 32'd0);
    tick(1, 0);
    chk("w4_armed", {31'd0, bus4.armed}, 32'd1);
    chk("w4_state", {30'd0, bus4.status[1:0]}, 32'd1);
    chk("w4_nosync", {31'd0, bus4.sync_out}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
